// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the Hmmm data-path SRAM responder.
// Two 16-bit Hmmm words are packed into each 32-bit SRAM word.
package ram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_WAIT,
        DONE
    } state_t;

    localparam logic [3:0] WMASK_LO   = 4'b0011;
    localparam logic [3:0] WMASK_HI   = 4'b1100;
    localparam logic [3:0] WMASK_NONE = 4'b0000;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 3;

    // Odd Hmmm addresses live in the upper half of the SRAM word.
    function automatic logic [15:0] half_sel(input logic [31:0] word, input logic hi);
        return hi ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/ram_ctrl.sv
// Sequences Hmmm word reads/writes onto a single-port synchronous SRAM
// (active-low csb/web, byte mask) and acknowledges each with a one-cycle pulse.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       ram_in,
    output logic [15:0]       ram_out,
    output logic              ack,
    output logic              busy,
    output logic              conflict,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [3:0]        sram_wmask,
    output logic [ADDR_W-2:0] sram_addr,
    output logic [31:0]       sram_din,
    input  logic [31:0]       sram_dout
);

    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
        $error("ram_ctrl: READ_LAT must be in 1..3");
    end

    localparam logic [1:0] LAST_CNT = 2'(READ_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        lat_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic              accept;

    assign accept = (state == IDLE) && (req_read || req_write);

    // Transaction operands are frozen at accept so the requester may move on.
    assign sram_addr = addr_q[ADDR_W-1:1];
    assign sram_din  = {wdata_q, wdata_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lat_cnt  <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= 16'd0;
            ram_out  <= 16'd0;
            conflict <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= ram_in;
            end
            if (state == IDLE && req_read && req_write) begin
                conflict <= 1'b1;
            end
            if (state == RD_WAIT) begin
                lat_cnt <= lat_cnt + 2'd1;
            end else begin
                lat_cnt <= 2'd0;
            end
            if (state == RD_WAIT && lat_cnt == LAST_CNT) begin
                ram_out <= half_sel(sram_dout, addr_q[0]);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_wmask = WMASK_NONE;
        ack        = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                // A simultaneous read is dropped in favour of the write.
                if (req_write) begin
                    state_nxt = WRITE;
                end else if (req_read) begin
                    state_nxt = RD_ISSUE;
                end
            end
            WRITE: begin
                sram_csb   = 1'b0;
                sram_web   = 1'b0;
                sram_wmask = addr_q[0] ? WMASK_HI : WMASK_LO;
                state_nxt  = DONE;
            end
            RD_ISSUE: begin
                sram_csb  = 1'b0;
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_cnt == LAST_CNT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ack       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: one instance at READ_LAT=1 and one at READ_LAT=3,
// each attached to a behavioural SRAM with matching read latency.
module tb_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_read;
    logic        req_write;
    logic [7:0]  addr;
    logic [15:0] ram_in;

    logic        req_read_a, req_write_a, req_read_b, req_write_b;
    logic [15:0] ram_out_a, ram_out_b;
    logic        ack_a, ack_b, busy_a, busy_b, conflict_a, conflict_b;
    logic        csb_a, csb_b, web_a, web_b;
    logic [3:0]  wmask_a, wmask_b;
    logic [6:0]  saddr_a, saddr_b;
    logic [31:0] din_a, din_b, dout_a, dout_b;

    logic [31:0] mem_a [128];
    logic [31:0] mem_b [128];
    logic [31:0] pipe_a0;
    logic [31:0] pipe_b0, pipe_b1, pipe_b2;
    int          wr_cnt_a = 0;
    int          wr_cnt_b = 0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign req_read_a  = req_read  & ~sel;
    assign req_write_a = req_write & ~sel;
    assign req_read_b  = req_read  &  sel;
    assign req_write_b = req_write &  sel;

    ram_ctrl #(.ADDR_W(8), .READ_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .req_read(req_read_a), .req_write(req_write_a),
        .addr(addr), .ram_in(ram_in), .ram_out(ram_out_a), .ack(ack_a),
        .busy(busy_a), .conflict(conflict_a), .sram_csb(csb_a), .sram_web(web_a),
        .sram_wmask(wmask_a), .sram_addr(saddr_a), .sram_din(din_a), .sram_dout(dout_a)
    );

    ram_ctrl #(.ADDR_W(8), .READ_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .req_read(req_read_b), .req_write(req_write_b),
        .addr(addr), .ram_in(ram_in), .ram_out(ram_out_b), .ack(ack_b),
        .busy(busy_b), .conflict(conflict_b), .sram_csb(csb_b), .sram_web(web_b),
        .sram_wmask(wmask_b), .sram_addr(saddr_b), .sram_din(din_b), .sram_dout(dout_b)
    );

    // SRAM models: read data is only valid in the single cycle READ_LAT after issue.
    always @(posedge clk) begin
        if (!csb_a && !web_a) begin
            for (int b = 0; b < 4; b++)
                if (wmask_a[b]) mem_a[saddr_a][8*b +: 8] <= din_a[8*b +: 8];
            wr_cnt_a <= wr_cnt_a + 1;
        end
        pipe_a0 <= (!csb_a && web_a) ? mem_a[saddr_a] : 32'hDEAD_DEAD;
    end
    assign dout_a = pipe_a0;

    always @(posedge clk) begin
        if (!csb_b && !web_b) begin
            for (int b = 0; b < 4; b++)
                if (wmask_b[b]) mem_b[saddr_b][8*b +: 8] <= din_b[8*b +: 8];
            wr_cnt_b <= wr_cnt_b + 1;
        end
        pipe_b0 <= (!csb_b && web_b) ? mem_b[saddr_b] : 32'hDEAD_DEAD;
        pipe_b1 <= pipe_b0;
        pipe_b2 <= pipe_b1;
    end
    assign dout_b = pipe_b2;

    logic [15:0] o_ram_out;
    logic        o_ack, o_busy, o_conflict, o_csb, o_web;
    logic [3:0]  o_wmask;
    logic [6:0]  o_saddr;
    logic [31:0] o_din;
    assign o_ram_out  = sel ? ram_out_b  : ram_out_a;
    assign o_ack      = sel ? ack_b      : ack_a;
    assign o_busy     = sel ? busy_b     : busy_a;
    assign o_conflict = sel ? conflict_b : conflict_a;
    assign o_csb      = sel ? csb_b      : csb_a;
    assign o_web      = sel ? web_b      : web_a;
    assign o_wmask    = sel ? wmask_b    : wmask_a;
    assign o_saddr    = sel ? saddr_b    : saddr_a;
    assign o_din      = sel ? din_b      : din_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called at the start of an IDLE cycle; returns at the start of the next IDLE cycle.
    task automatic do_write(input logic [7:0] a, input logic [15:0] d, input bit also_rd);
        int wc0;
        wc0 = sel ? wr_cnt_b : wr_cnt_a;
        addr = a; ram_in = d; req_write = 1'b1; req_read = also_rd;
        @(negedge clk);
        check("wr_c0_busy", 32'(o_busy), 32'd0);
        check("wr_c0_ack", 32'(o_ack), 32'd0);
        next_cycle();
        req_write = 1'b0; req_read = 1'b0; addr = ~a; ram_in = ~d;
        @(negedge clk);
        check("wr_c1_csb", 32'(o_csb), 32'd0);
        check("wr_c1_web", 32'(o_web), 32'd0);
        check("wr_c1_wmask", 32'(o_wmask), a[0] ? 32'hC : 32'h3);
        check("wr_c1_saddr", 32'(o_saddr), 32'(a[7:1]));
        check("wr_c1_din", o_din, {d, d});
        check("wr_c1_ack", 32'(o_ack), 32'd0);
        next_cycle();
        @(negedge clk);
        check("wr_c2_ack", 32'(o_ack), 32'd1);
        check("wr_c2_csb", 32'(o_csb), 32'd1);
        check("wr_c2_count", sel ? wr_cnt_b : wr_cnt_a, wc0 + 1);
        next_cycle();
    endtask

    task automatic do_read(input logic [7:0] a, input logic [15:0] exp);
        int lat;
        lat = sel ? 3 : 1;
        addr = a; req_read = 1'b1;
        @(negedge clk);
        check("rd_c0_busy", 32'(o_busy), 32'd0);
        check("rd_c0_ack", 32'(o_ack), 32'd0);
        next_cycle();
        req_read = 1'b0; addr = ~a;
        @(negedge clk);
        check("rd_c1_csb", 32'(o_csb), 32'd0);
        check("rd_c1_web", 32'(o_web), 32'd1);
        check("rd_c1_wmask", 32'(o_wmask), 32'd0);
        check("rd_c1_saddr", 32'(o_saddr), 32'(a[7:1]));
        for (int i = 0; i < lat; i++) begin
            next_cycle();
            @(negedge clk);
            check("rd_wait_csb", 32'(o_csb), 32'd1);
            check("rd_wait_ack", 32'(o_ack), 32'd0);
        end
        next_cycle();
        @(negedge clk);
        check("rd_done_ack", 32'(o_ack), 32'd1);
        check("rd_done_data", 32'(o_ram_out), 32'(exp));
        next_cycle();
    endtask

    initial begin
        int          wc0;
        logic [5:0]  exp_ack;
        logic [5:0]  exp_busy;

        for (int i = 0; i < 128; i++) begin
            mem_a[i] = 32'd0;
            mem_b[i] = 32'd0;
        end
        rst = 1'b1; sel = 1'b0; req_read = 1'b0; req_write = 1'b0;
        addr = 8'd0; ram_in = 16'd0;
        repeat (3) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_ram_out", 32'(ram_out_a), 32'd0);
        check("rst_ack", 32'(ack_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_conflict", 32'(conflict_a), 32'd0);
        check("rst_csb", 32'(csb_a), 32'd1);
        check("rst_web", 32'(web_a), 32'd1);
        check("rst_wmask", 32'(wmask_a), 32'd0);
        check("rst_din", din_a, 32'd0);
        check("rst_saddr", 32'(saddr_a), 32'd0);
        next_cycle();

        // Basic write/read and half-word packing at READ_LAT=1.
        do_write(8'h10, 16'hBEEF, 1'b0);
        do_read(8'h10, 16'hBEEF);
        do_write(8'h11, 16'h1234, 1'b0);
        do_write(8'h10, 16'hABCD, 1'b0);
        check("pack_word", mem_a[8], 32'h1234_ABCD);
        do_read(8'h11, 16'h1234);
        do_read(8'h10, 16'hABCD);
        check("conflict_clear", 32'(conflict_a), 32'd0);

        // Read and write together: only the write lands, conflict sticks.
        do_write(8'h20, 16'h0F0F, 1'b1);
        check("conflict_set", 32'(conflict_a), 32'd1);
        check("conflict_mem", mem_a[16], 32'h0000_0F0F);
        do_read(8'h20, 16'h0F0F);
        check("conflict_sticky", 32'(conflict_a), 32'd1);

        // Reset during RD_WAIT aborts the read without an ack.
        addr = 8'h10; req_read = 1'b1;
        next_cycle();
        req_read = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_busy", 32'(busy_a), 32'd0);
        check("rstmid_ack", 32'(ack_a), 32'd0);
        check("rstmid_ram_out", 32'(ram_out_a), 32'd0);
        check("rstmid_csb", 32'(csb_a), 32'd1);
        check("rstmid_conflict", 32'(conflict_a), 32'd0);
        next_cycle();
        @(negedge clk);
        check("rstmid_no_late_ack", 32'(ack_a), 32'd0);
        next_cycle();

        // A write request coinciding with reset is never issued.
        wc0 = wr_cnt_a;
        addr = 8'h40; ram_in = 16'h9999; req_write = 1'b1; rst = 1'b1;
        next_cycle();
        req_write = 1'b0; rst = 1'b0;
        repeat (2) next_cycle();
        check("rst_no_write", wr_cnt_a, wc0);
        check("rst_no_write_mem", mem_a[32], 32'd0);

        // Held write request: back-to-back transactions with one IDLE between.
        wc0 = wr_cnt_a;
        exp_ack  = 6'b100100;
        exp_busy = 6'b110110;
        addr = 8'h31; ram_in = 16'h7777; req_write = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("held_ack", 32'(ack_a), 32'(exp_ack[c]));
            check("held_busy", 32'(busy_a), 32'(exp_busy[c]));
            next_cycle();
        end
        req_write = 1'b0;
        check("held_count", wr_cnt_a, wc0 + 2);
        check("held_mem", mem_a[24], 32'h7777_0000);
        next_cycle();

        // READ_LAT=3, top of the address space.
        sel = 1'b1;
        do_write(8'hFF, 16'h5A5A, 1'b0);
        check("lat3_mem", mem_b[127], 32'h5A5A_0000);
        do_read(8'hFF, 16'h5A5A);
        check("lat3_conflict", 32'(conflict_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
